calc_seq: RTL and testbench

Sequencing controller for the `calc` neuron datapath (ALU + aggregator with activation). On `start` it evaluates `N_NEU` neurons in turn. For each neuron it:
- clears the aggregator,
- streams `N_IN` input bits and the matching weight bits from two synchronous-read memories into `calc_1` / `calc_in`,
- captures the activated result `agg_out_acted` into an output vector.

It sits between the layer-level memories and one `calc` instance, and owns that instance.

---
 rtl/calc_seq_pkg.sv | 20 ++
 rtl/calc_seq.sv | 163 ++++++++++++++++
 tb/tb_calc_seq.sv | 284 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/calc_seq_pkg.sv
// Purpose: shared types and default sizing for the calc neuron sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package calc_seq_pkg;

   // Default layer geometry: 16 binary inputs per neuron, 8 neurons.
   localparam int N_IN  = 16;
   localparam int N_NEU = 8;
   localparam int IA_W  = 4;   // input-bit memory address width
   localparam int WA_W  = 7;   // weight memory address width

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_CLEAR,
      ST_RUN,
      ST_ACT,
      ST_DONE
   } state_t;

endpackage

// File: rtl/calc_seq.sv
// Purpose: walks N_NEU neurons through one calc datapath, streaming input/weight bits from 1-cycle ROMs.
// Latency: done pulses N_NEU*(N_IN+2)+1 cycles after the start edge; each neuron takes CLEAR + N_IN RUN + ACT.
// Backpressure: none; memories are fixed 1-cycle latency, and start is sampled only in IDLE (no queueing).
//
// Ports:
//   clk, rst (async, active-low)        clock and reset
//   start / busy / done                 run request, in-progress flag, one-cycle completion pulse
//   in_addr, in_bit, w_addr, w_bit      read address out, read data in (data one cycle after address)
//   rd_en                               shared read strobe for both memories
//   calc_1, calc_in, calc_clr           drive the owned calc instance
//   agg_out_acted                       activated aggregator result from calc
//   out_vec, out_valid                  per-neuron results and "complete, current" flag
module calc_seq
   import calc_seq_pkg::*;
#(
   parameter int N_IN  = calc_seq_pkg::N_IN,
   parameter int N_NEU = calc_seq_pkg::N_NEU,
   parameter int IA_W  = calc_seq_pkg::IA_W,
   parameter int WA_W  = calc_seq_pkg::WA_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   output logic             busy,
   output logic             done,
   output logic [IA_W-1:0]  in_addr,
   input  logic             in_bit,
   output logic [WA_W-1:0]  w_addr,
   input  logic             w_bit,
   output logic             rd_en,
   output logic             calc_1,
   output logic             calc_in,
   output logic             calc_clr,
   input  logic             agg_out_acted,
   output logic [N_NEU-1:0] out_vec,
   output logic             out_valid
);

   localparam int              NW     = (N_NEU > 1) ? $clog2(N_NEU) : 1;
   localparam logic [IA_W-1:0] K_LAST = IA_W'(N_IN - 1);
   localparam logic [IA_W-1:0] K_PEN  = IA_W'(N_IN - 2);
   localparam logic [NW-1:0]   N_LAST = NW'(N_NEU - 1);

   state_t           state_q, state_d;
   logic [IA_W-1:0]  k_q, k_d;
   logic [NW-1:0]    n_q, n_d;
   logic             rd_en_q, rd_en_d;
   logic [IA_W-1:0]  in_addr_q, in_addr_d;
   logic [WA_W-1:0]  w_addr_q, w_addr_d;
   logic [N_NEU-1:0] out_vec_q, out_vec_d;
   logic             out_valid_q, out_valid_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= ST_IDLE;
         k_q         <= '0;
         n_q         <= '0;
         rd_en_q     <= 1'b0;
         in_addr_q   <= '0;
         w_addr_q    <= '0;
         out_vec_q   <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         k_q         <= k_d;
         n_q         <= n_d;
         rd_en_q     <= rd_en_d;
         in_addr_q   <= in_addr_d;
         w_addr_q    <= w_addr_d;
         out_vec_q   <= out_vec_d;
         out_valid_q <= out_valid_d;
      end
   end

   // The read strobe and addresses are registered: each branch computes what
   // the memories must see in the *next* cycle. Weight addresses are issued
   // strictly sequentially (n*N_IN .. n*N_IN+N_IN-1, then the next neuron's
   // base), so an incrementer replaces the n*N_IN multiply. Addresses hold
   // whenever rd_en_d stays low.
   always_comb begin
      state_d     = state_q;
      k_d         = k_q;
      n_d         = n_q;
      rd_en_d     = 1'b0;
      in_addr_d   = in_addr_q;
      w_addr_d    = w_addr_q;
      out_vec_d   = out_vec_q;
      out_valid_d = out_valid_q;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d     = ST_CLEAR;
               n_d         = '0;
               out_valid_d = 1'b0;
               rd_en_d     = 1'b1;
               in_addr_d   = '0;
               w_addr_d    = '0;
            end
         end

         ST_CLEAR: begin
            // Index 0 was fetched during CLEAR; first RUN cycle fetches index 1.
            state_d   = ST_RUN;
            k_d       = '0;
            rd_en_d   = 1'b1;
            in_addr_d = in_addr_q + 1'b1;
            w_addr_d  = w_addr_q + 1'b1;
         end

         ST_RUN: begin
            if (k_q == K_LAST) begin
               state_d = ST_ACT;
            end else begin
               k_d = k_q + 1'b1;
               // Fetch index k+2 unless k+1 is already the last index.
               if (k_q != K_PEN) begin
                  rd_en_d   = 1'b1;
                  in_addr_d = in_addr_q + 1'b1;
                  w_addr_d  = w_addr_q + 1'b1;
               end
            end
         end

         ST_ACT: begin
            for (int i = 0; i < N_NEU; i++) begin
               if (NW'(i) == n_q) out_vec_d[i] = agg_out_acted;
            end
            if (n_q == N_LAST) begin
               state_d = ST_DONE;
            end else begin
               state_d   = ST_CLEAR;
               n_d       = n_q + 1'b1;
               rd_en_d   = 1'b1;
               in_addr_d = '0;
               w_addr_d  = w_addr_q + 1'b1;
            end
         end

         ST_DONE: begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b1;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign busy      = (state_q != ST_IDLE);
   assign done      = (state_q == ST_DONE);
   assign calc_clr  = (state_q == ST_IDLE) || (state_q == ST_CLEAR) || (state_q == ST_DONE);
   // Memory data is only meaningful in RUN; elsewhere the aggregator sees zeros.
   assign calc_1    = (state_q == ST_RUN) && in_bit;
   assign calc_in   = (state_q == ST_RUN) && w_bit;
   assign rd_en     = rd_en_q;
   assign in_addr   = in_addr_q;
   assign w_addr    = w_addr_q;
   assign out_vec   = out_vec_q;
   assign out_valid = out_valid_q;

endmodule

// File: tb/tb_calc_seq.sv
// Purpose: self-checking bench for calc_seq with a calc aggregator model and two 1-cycle ROMs.
// Latency: checks done at N_NEU*(N_IN+2)+1 cycles after the start edge.
// Backpressure: none in the design; the bench drives start directly.
module tb_calc_seq;

   localparam int NI  = calc_seq_pkg::N_IN;
   localparam int NN  = calc_seq_pkg::N_NEU;
   localparam int IAW = calc_seq_pkg::IA_W;
   localparam int WAW = calc_seq_pkg::WA_W;
   localparam int RUN_CYC = NN * (NI + 2) + 1;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   // ---------------- main DUT (default geometry) ----------------
   logic           start, busy, done, in_bit, w_bit, rd_en;
   logic           calc_1, calc_in, calc_clr, agg_out_acted, out_valid;
   logic [IAW-1:0] in_addr;
   logic [WAW-1:0] w_addr;
   logic [NN-1:0]  out_vec;

   calc_seq dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .in_addr(in_addr), .in_bit(in_bit), .w_addr(w_addr), .w_bit(w_bit),
      .rd_en(rd_en), .calc_1(calc_1), .calc_in(calc_in), .calc_clr(calc_clr),
      .agg_out_acted(agg_out_acted), .out_vec(out_vec), .out_valid(out_valid)
   );

   logic in_mem [NI];
   logic w_mem  [NI*NN];

   always_ff @(posedge clk) begin
      if (rd_en) begin
         in_bit <= in_mem[in_addr];
         w_bit  <= w_mem[w_addr];
      end
   end

   // calc datapath: AND product accumulated while not cleared, activation = sum > 0.
   logic [7:0] acc;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                  acc <= '0;
      else if (calc_clr)         acc <= '0;
      else if (calc_1 & calc_in) acc <= acc + 8'd1;
   end
   assign agg_out_acted = (acc > 8'd0);

   // ---------------- small DUT (N_IN=2, N_NEU=1) ----------------
   logic       start_s, busy_s, done_s, in_bit_s, w_bit_s, rd_en_s;
   logic       calc_1_s, calc_in_s, calc_clr_s, agg_s, out_valid_s;
   logic [0:0] in_addr_s, w_addr_s, out_vec_s;

   calc_seq #(.N_IN(2), .N_NEU(1), .IA_W(1), .WA_W(1)) dut_s (
      .clk(clk), .rst(rst), .start(start_s), .busy(busy_s), .done(done_s),
      .in_addr(in_addr_s), .in_bit(in_bit_s), .w_addr(w_addr_s), .w_bit(w_bit_s),
      .rd_en(rd_en_s), .calc_1(calc_1_s), .calc_in(calc_in_s), .calc_clr(calc_clr_s),
      .agg_out_acted(agg_s), .out_vec(out_vec_s), .out_valid(out_valid_s)
   );

   // Only index 1 holds a 1 in both memories, so the result depends on addressing.
   always_ff @(posedge clk) begin
      if (rd_en_s) begin
         in_bit_s <= in_addr_s[0];
         w_bit_s  <= w_addr_s[0];
      end
   end

   logic [3:0] acc_s;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                      acc_s <= '0;
      else if (calc_clr_s)           acc_s <= '0;
      else if (calc_1_s & calc_in_s) acc_s <= acc_s + 4'd1;
   end
   assign agg_s = (acc_s > 4'd0);

   // ---------------- bench state ----------------
   int vectors    = 0;
   int miscompares = 0;
   logic [NN-1:0] exp_q[$];

   logic           rd_log  [0:511];
   logic           clr_log [0:511];
   logic [IAW-1:0] ia_log  [0:511];
   logic [WAW-1:0] wa_log  [0:511];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NN-1:0] golden();
      logic [NN-1:0] r;
      r = '0;
      for (int n = 0; n < NN; n++) begin
         int sum;
         sum = 0;
         for (int k = 0; k < NI; k++) sum += int'(in_mem[k] & w_mem[n*NI + k]);
         r[n] = (sum > 0);
      end
      return r;
   endfunction

   task automatic log_cycle(input int c);
      rd_log[c]  = rd_en;
      clr_log[c] = calc_clr;
      ia_log[c]  = in_addr;
      wa_log[c]  = w_addr;
   endtask

   // Called at a negedge: raises start, pushes the expected result, returns
   // at the negedge after the accept edge (cycle 1 = CLEAR of neuron 0).
   task automatic launch(input bit hold);
      start = 1'b1;
      exp_q.push_back(golden());
      @(posedge clk);
      @(negedge clk);
      if (!hold) start = 1'b0;
   endtask

   // Counts cycles from CLEAR (cycle 1) until done is seen, logging outputs.
   task automatic run_dut(input int pulse_at, input int abort_at, output int cyc);
      cyc = 1;
      log_cycle(1);
      while (!done && cyc != abort_at && cyc < 400) begin
         @(posedge clk);
         @(negedge clk);
         cyc++;
         if (pulse_at != 0 && cyc == pulse_at) begin
            start = 1'b1;
         end else if (pulse_at != 0 && cyc == pulse_at + 1) begin
            start = 1'b0;
            check("ignored_start_busy", busy, 1);
         end
         log_cycle(cyc);
      end
   endtask

   task automatic finish_run(input string tag, input int cyc);
      logic [NN-1:0] exp;
      check({tag, "_done"}, done, 1);
      check({tag, "_latency"}, cyc, RUN_CYC);
      exp = exp_q.pop_front();
      check({tag, "_out_vec"}, out_vec, exp);
   endtask

   initial begin
      int cyc;
      int bad;
      int j;
      start   = 1'b0;
      start_s = 1'b0;
      for (int k = 0; k < NI; k++) in_mem[k] = 1'b0;
      for (int i = 0; i < NI*NN; i++) w_mem[i] = 1'b0;

      // Reset state, held in reset.
      repeat (2) @(negedge clk);
      check("rst_busy", busy, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_calc_clr", calc_clr, 1);
      check("rst_out_vec", out_vec, 0);
      check("rst_rd_en", rd_en, 0);
      rst = 1'b1;
      @(negedge clk);

      // Single run: all inputs 1, neuron n weights = (n odd).
      for (int k = 0; k < NI; k++) in_mem[k] = 1'b1;
      for (int n = 0; n < NN; n++)
         for (int k = 0; k < NI; k++) w_mem[n*NI + k] = n[0];
      launch(1'b0);
      run_dut(0, 0, cyc);
      check("run1_calc_clr_done", calc_clr, 1);
      finish_run("run1", cyc);
      check("run1_aa", out_vec, 32'hAA);

      // Neuron 2 addressing: window is its CLEAR..ACT cycles.
      bad = 0;
      j   = 0;
      for (int c = 1 + 2*(NI+2); c <= 3*(NI+2); c++) begin
         if (rd_log[c]) begin
            if (ia_log[c] !== IAW'(j) || wa_log[c] !== WAW'(2*NI + j)) bad++;
            j++;
         end
      end
      check("n2_rd_cycles", j, NI);
      check("n2_addr_order", bad, 0);

      // calc_clr high in each CLEAR, low across the following RUN+ACT cycles.
      bad = 0;
      for (int n = 0; n < NN; n++) begin
         int base;
         base = 1 + n*(NI+2);
         if (clr_log[base] !== 1'b1) bad++;
         for (int c = base + 1; c <= base + NI + 1; c++)
            if (clr_log[c] !== 1'b0) bad++;
      end
      check("clr_spacing", bad, 0);

      @(posedge clk);
      @(negedge clk);
      check("idle_out_valid", out_valid, 1);
      check("idle_busy", busy, 0);

      // start pulsed mid-RUN must be ignored (timing unchanged).
      launch(1'b0);
      check("run2_out_valid_drop", out_valid, 0);
      run_dut(10, 0, cyc);
      finish_run("run2", cyc);

      // start held: relaunch one cycle after DONE.
      @(posedge clk);
      @(negedge clk);
      launch(1'b1);
      run_dut(0, 0, cyc);
      finish_run("held1", cyc);
      @(posedge clk);
      @(negedge clk);
      check("held_idle_busy", busy, 0);
      check("held_idle_out_valid", out_valid, 1);
      exp_q.push_back(golden());
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      check("held_restart_busy", busy, 1);
      check("held_restart_out_valid", out_valid, 0);
      run_dut(0, 0, cyc);
      finish_run("held2", cyc);
      @(posedge clk);
      @(negedge clk);

      // Reset mid-RUN of neuron 3; partial run discarded.
      launch(1'b0);
      run_dut(0, 3*(NI+2) + 6, cyc);
      check("pre_rst_busy", busy, 1);
      rst = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_out_vec", out_vec, 0);
      check("mid_rst_out_valid", out_valid, 0);
      check("mid_rst_calc_clr", calc_clr, 1);
      check("mid_rst_rd_en", rd_en, 0);
      check("mid_rst_done", done, 0);
      check("mid_rst_addr", {in_addr, w_addr}, 0);
      void'(exp_q.pop_back());
      rst = 1'b1;
      @(negedge clk);

      // Small geometry: done 5 cycles after start edge.
      start_s = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_s = 1'b0;
      cyc = 1;
      bad = (calc_clr_s !== 1'b1) ? 1 : 0;
      while (!done_s && cyc < 50) begin
         @(posedge clk);
         @(negedge clk);
         cyc++;
         if (!done_s && calc_clr_s !== 1'b0) bad++;
      end
      check("small_latency", cyc, 5);
      check("small_clr_spacing", bad, 0);
      check("small_out_vec", out_vec_s, 1);

      // Mixed random data, 20 runs, sparse weights so results vary.
      for (int s = 0; s < 20; s++) begin
         for (int k = 0; k < NI; k++) in_mem[k] = 1'($urandom_range(0, 1));
         for (int i = 0; i < NI*NN; i++) w_mem[i] = ($urandom_range(0, 11) == 0);
         launch(1'b0);
         run_dut(0, 0, cyc);
         finish_run("rand", cyc);
         @(posedge clk);
         @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
